// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: chip-enable and branch
// levels plus the fetch FSM state encoding.
package pc_gen_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic BRANCH       = 1'b1;
    localparam logic NOT_BRANCH   = 1'b0;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_HOLD_BR = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// Instruction fetch PC generator with stall, branch, flush and a one-deep pending branch.
// Optional macro PC_MISALIGN_CHECK_EN: align redirect targets and pulse misalign_o.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                INST_BYTES   = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              br_pend_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

    pc_state_e         state_reg;
    logic [ADDR_W-1:0] pend_addr_reg;

    logic [ADDR_W-1:0] br_addr;
    logic [ADDR_W-1:0] flush_addr;
    logic              br_mis;
    logic              flush_mis;

`ifdef PC_MISALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    assign br_addr    = branch_target_address_i & ~LOW_MASK;
    assign flush_addr = new_pc_i & ~LOW_MASK;
    assign br_mis     = |(branch_target_address_i & LOW_MASK);
    assign flush_mis  = |(new_pc_i & LOW_MASK);
`else
    assign br_addr    = branch_target_address_i;
    assign flush_addr = new_pc_i;
    assign br_mis     = 1'b0;
    assign flush_mis  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_OFF;
            pc            <= RESET_VECTOR;
            ce            <= CHIP_DISABLE;
            pend_addr_reg <= '0;
            br_pend_o     <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state_reg)
                // First edge out of reset only enables fetch; pc stays at the vector.
                ST_OFF: begin
                    state_reg <= ST_RUN;
                    ce        <= CHIP_ENABLE;
                end
                default: begin
                    if (flush_i) begin
                        pc            <= flush_addr;
                        pend_addr_reg <= '0;
                        br_pend_o     <= 1'b0;
                        misalign_o    <= flush_mis;
                        state_reg     <= ST_RUN;
                    end else if (branch_flag_i == BRANCH) begin
                        misalign_o <= br_mis;
                        if (stall_i) begin
                            // Newer branch while stalled replaces any earlier capture.
                            pend_addr_reg <= br_addr;
                            br_pend_o     <= 1'b1;
                            state_reg     <= ST_HOLD_BR;
                        end else begin
                            pc            <= br_addr;
                            pend_addr_reg <= '0;
                            br_pend_o     <= 1'b0;
                            state_reg     <= ST_RUN;
                        end
                    end else if (state_reg == ST_HOLD_BR && !stall_i) begin
                        pc            <= pend_addr_reg;
                        pend_addr_reg <= '0;
                        br_pend_o     <= 1'b0;
                        state_reg     <= ST_RUN;
                    end else if (stall_i) begin
                        if (state_reg != ST_HOLD_BR) begin
                            state_reg <= ST_HOLD;
                        end
                    end else begin
                        pc        <= pc + PC_INC;
                        state_reg <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen: reset, sequential fetch, stall/branch/flush
// interactions, wrap-around and the optional misalignment handling.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [31:0] pc;
    logic        ce;
    logic        br_pend_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W      (32),
        .INST_BYTES  (4),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall_i                (stall_i),
        .branch_flag_i          (branch_flag_i),
        .branch_target_address_i(branch_target_address_i),
        .flush_i                (flush_i),
        .new_pc_i               (new_pc_i),
        .pc                     (pc),
        .ce                     (ce),
        .br_pend_o              (br_pend_o),
        .misalign_o             (misalign_o)
    );

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] target;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[25];

`ifdef PC_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_ce,
                             input logic e_pend, input logic e_mis);
        check({tag, ".pc"},   pc,                 e_pc);
        check({tag, ".ce"},   {31'd0, ce},        {31'd0, e_ce});
        check({tag, ".pend"}, {31'd0, br_pend_o}, {31'd0, e_pend});
        check({tag, ".mis"},  {31'd0, misalign_o}, {31'd0, e_mis});
        $display("%s: pc=0x%08h ce=%0b pend=%0b mis=%0b", tag, pc, ce, br_pend_o, misalign_o);
    endtask

    task automatic set_in(input logic s, input logic b, input logic [31:0] t,
                          input logic f, input logic [31:0] n);
        stall_i                 = s;
        branch_flag_i           = b;
        branch_target_address_i = t;
        flush_i                 = f;
        new_pc_i                = n;
    endtask

    initial begin
        //            stall br  target         flush new_pc        exp_pc                    pend mis
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4,                    1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8,                    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hC,                    1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h10,                   1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h10,                   1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h10,                   1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,                  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,                  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,                  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h104,                  1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h180,      32'h180,                  1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h184,                  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h184,                  1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'h140,      1'b0, 32'h0,        32'h184,                  1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h140,                  1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h140,                  1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        32'h200,                  1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h204,                  1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC,             1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,                    1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 32'h103,      1'b0, 32'h0,        MIS ? 32'h100 : 32'h103,  1'b0, MIS};
        vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        MIS ? 32'h104 : 32'h107,  1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 32'h203,      1'b0, 32'h0,        MIS ? 32'h104 : 32'h107,  1'b1, MIS};
        vecs[23] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        MIS ? 32'h200 : 32'h203,  1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h2,        MIS ? 32'h0 : 32'h2,      1'b0, MIS};

        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held", 32'h0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        #1;
        check_all("release_cycle", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("first_run", 32'h0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            set_in(vecs[i].stall, vecs[i].branch, vecs[i].target, vecs[i].flush, vecs[i].new_pc);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, 1'b1, vecs[i].exp_pend, vecs[i].exp_mis);
        end

        // Asynchronous reset while a branch is pending must clear everything at once.
        set_in(1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check_all("pend_before_rst", MIS ? 32'h0 : 32'h2, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);

        // Branch and flush presented during OFF must be ignored.
        @(posedge clk);
        #1;
        set_in(1'b0, 1'b1, 32'h700, 1'b1, 32'h7C0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("off_ignores", 32'h0, 1'b1, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check_all("after_off", 32'h4, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
